// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame geometry,
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_baud_gen.sv
// Bit-period counter for the UART transmitter: counts 0..CLKS_PER_BIT-1 and flags
// the last cycle of each serial bit. Clearing restarts the period from zero.
module tx_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_end = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word on a valid/ready handshake and serialises it as
// start bit, WIDTH data bits (LSB first) and stop bit, each CLKS_PER_BIT clocks long.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);

    tx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [BW-1:0]    bit_cnt, bit_cnt_next;
    logic             tx_next, done_next;
    logic             accept, bit_end;

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;

    // Clearing on acceptance phase-aligns every bit boundary to the accepting edge.
    tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
            done    <= done_next;
        end
    end

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    shreg_next   = tx_data;
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shreg_next   = shreg >> 1;
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt_next == BW'(WIDTH)) state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered, so it is computed from the state being entered.
    always_comb begin
        tx_next   = 1'b1;
        done_next = (state == STOP) && (state_next == IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed testbench for uart_tx with WIDTH=8, CLKS_PER_BIT=4 (41-cycle frame spacing).
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx #(
        .WIDTH       (8),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word and checks every cycle of the frame. Returns the ten mid-bit
    // samples (start, d0..d7, stop) with the start bit in bit 0.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] d_late,
                              input bit poke, output logic [9:0] samples);
        int   errs;
        int   ready_errs;
        int   idx;
        logic exp_bit;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        tx_valid   = 1'b0;
        errs       = 0;
        ready_errs = 0;
        samples    = '0;
        for (int k = 1; k <= 40; k++) begin
            idx = (k - 1) / 4;
            if (idx == 0)      exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else               exp_bit = d[idx-1];
            if (tx !== exp_bit || busy !== 1'b1 || done !== 1'b0) errs++;
            if (tx_ready !== 1'b0) ready_errs++;
            if ((k - 1) % 4 == 2) samples[idx] = tx;
            if (k == 5) tx_data = d_late;
            if (poke && k == 12) tx_valid = 1'b1;
            if (poke && k == 14) tx_valid = 1'b0;
            tick();
        end
        check("frame_cycles", errs, 0);
        check("ready_low_in_frame", ready_errs, 0);
        check("rx_word", samples[8:1], d);
        check("done_pulse", done, 1);
        check("idle_after_frame", {tx, busy, tx_ready}, 3'b101);
        tick();
        check("done_cleared", done, 0);
        check("no_extra_frame", {tx, busy}, 2'b10);
    endtask

    initial begin
        logic [9:0] s;
        logic [7:0] w1, w2;
        logic [7:0] rnd;
        int ready_cnt, start2, stray_done, d41, d82, idx;

        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) tick();
        check("reset_state", {tx, busy, done, tx_ready}, 4'b1001);
        reset = 1'b1;
        tick();
        check("idle_after_release", {tx, busy, done, tx_ready}, 4'b1001);

        // 0xA5 frame: line pattern 0,1,0,1,0,0,1,0,1,1
        send_frame(8'hA5, 8'hA5, 1'b0, s);
        check("a5_line_pattern", s, 10'b1101001010);

        // data changed to 0x3C mid-frame, frame still carries 0xA5
        send_frame(8'hA5, 8'h3C, 1'b0, s);
        check("latched_word", s[8:1], 8'hA5);

        // tx_valid pulsed while busy: ignored, not queued
        send_frame(8'h81, 8'h81, 1'b1, s);

        // back-to-back 0x00 then 0xFF with tx_valid held high
        tx_data    = 8'h00;
        tx_valid   = 1'b1;
        tick();
        ready_cnt  = 0;
        start2     = 0;
        stray_done = 0;
        d41        = 0;
        d82        = 0;
        w1         = 8'hEE;
        w2         = 8'h00;
        for (int k = 1; k <= 82; k++) begin
            if (k < 82 && tx_ready) ready_cnt++;
            if (done) begin
                if (k == 41)      d41 = 1;
                else if (k == 82) d82 = 1;
                else              stray_done++;
            end
            if (k > 41 && tx == 1'b0 && start2 == 0) start2 = k;
            idx = (k - 1) / 4;
            if (k <= 40 && (k - 1) % 4 == 2 && idx >= 1 && idx <= 8) w1[idx-1] = tx;
            idx = (k - 42) / 4;
            if (k >= 42 && (k - 42) % 4 == 2 && idx >= 1 && idx <= 8) w2[idx-1] = tx;
            if (k == 20) tx_data = 8'hFF;
            if (k == 60) tx_valid = 1'b0;
            if (k < 82) tick();
        end
        check("b2b_ready_cycles", ready_cnt, 1);
        check("b2b_second_start", start2, 42);
        check("b2b_done_pulses", {d41[0], d82[0]}, 2'b11);
        check("b2b_stray_done", stray_done, 0);
        check("b2b_word0", w1, 8'h00);
        check("b2b_word1", w2, 8'hFF);
        tick();
        check("b2b_no_third", {tx, busy}, 2'b10);

        // reset during frame bit 3
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (12) tick();
        check("pre_reset_busy", busy, 1);
        reset = 1'b0;
        tick();
        check("abort_line", {tx, busy, done}, 3'b100);
        tick();
        check("abort_no_done", done, 0);
        reset = 1'b1;
        send_frame(8'h5A, 8'h5A, 1'b0, s);

        // loopback of random words through a mid-bit sampling receiver
        for (int i = 0; i < 256; i++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, ~rnd, 1'b0, s);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per frame.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, giving the clk cycles per serial bit; legal range is 2 or more.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-005 Port tx_data, input, WIDTH bits: parallel word to transmit.
REQ-006 Port tx_valid, input, 1 bit: tx_data is offered.
REQ-007 Port tx_ready, output, 1 bit: block can accept a word.
REQ-008 Port tx, output, 1 bit: serial line, idle high.
REQ-009 Port busy, output, 1 bit: a frame is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-011 Handshake: a word SHALL be accepted on the rising edge where tx_valid=1 and tx_ready=1.
REQ-012 tx_ready SHALL be 1 only in state IDLE; tx_valid while tx_ready=0 is ignored and is not queued.
REQ-013 On acceptance, tx_data SHALL be latched into an internal shift register; later changes to tx_data do not affect the frame in flight.
REQ-014 States SHALL be IDLE, START, DATA, STOP with transitions:
- IDLE->START on acceptance.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after WIDTH bit periods.
- STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 tx SHALL be registered, with value by state:
- IDLE: 1.
- START: 0.
- DATA: current bit, LSB first.
- STOP: 1.
REQ-016 Latency: tx SHALL go low in the first cycle after the accepting edge.
REQ-017 Every bit, including start and stop, SHALL be held for exactly CLKS_PER_BIT cycles; total frame is (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-018 The bit-period counter SHALL be cleared on acceptance, so bit timing is phase-aligned to acceptance and not free-running.
REQ-019 The bit-period counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at the end of each bit.
REQ-020 The data-bit counter SHALL be $clog2(WIDTH+1) bits wide; DATA exits when it reaches WIDTH.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 done SHALL be 1 for exactly the first IDLE cycle after STOP completes, and 0 otherwise.
REQ-023 Back-to-back: tx_valid held high SHALL start the next frame at the first IDLE cycle, giving a minimum frame spacing of (WIDTH+2)*CLKS_PER_BIT+1 cycles.
REQ-024 When the done cycle coincides with an acceptance, both SHALL occur: done=1 and the new frame starts.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL force state=IDLE, tx=1, tx_ready=1 (after release), busy=0, done=0, and clear all counters and the shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame, drive tx high on the next edge, and produce no done pulse.
REQ-027 The first acceptance after reset release SHALL be possible on the first edge with reset=1.

Structure
REQ-028 A shared package uart_pkg SHALL hold:
- the tx state typedef (IDLE/START/DATA/STOP);
- default WIDTH and CLKS_PER_BIT constants, also used by the receiver.
REQ-029 One sub-module, tx_baud_gen, SHALL hold the bit-period counter, with inputs clk, reset and clear, and a one-cycle output bit_end.
REQ-030 The FSM, shift register and bit counter SHALL live in uart_tx.

Verification
REQ-031 CLKS_PER_BIT=4, send 0xA5: tx SHALL be 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, with done pulsing at cycle 41 after acceptance.
REQ-032 tx_valid held high with 0x00 then 0xFF: frames SHALL be spaced 41 cycles, with tx_ready high for exactly one cycle between frames.
REQ-033 Change tx_data to 0x3C during a 0xA5 frame: the transmitted bits SHALL still be 0xA5.
REQ-034 Pulse tx_valid while busy=1: no extra frame SHALL be sent and tx_ready SHALL stay 0 until IDLE.
REQ-035 Assert reset=0 in bit 3 of a frame: tx=1, busy=0 and done=0 on the next edge, and a new frame SHALL be accepted after release.
REQ-036 Loopback tx into the team receiver with matching CLKS_PER_BIT: 256 random words SHALL all be received intact.
